mod_pack_scheduler: RTL and testbench

Sequences the byte stream into the Modulator's 8-bit input port and frames it into 1976-bit packs: a 32-bit preamble followed by 243 payload bytes.
At each pack boundary it decides between a data pack, taken from the upstream payload stream, and a blank pack (preamble + zeros), so the modulator output stays continuous.
Sits between the payload buffer and Modulator.i_data / i_valid_input / o_ready.

---
 rtl/mod_pack_scheduler_pkg.sv | 22 ++
 rtl/mod_pack_scheduler_preamble_rom.sv | 19 +
 rtl/mod_pack_scheduler.sv | 135 +++++++++++++
 tb/tb_mod_pack_scheduler.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mod_pack_scheduler_pkg.sv
// Shared pack geometry and scheduler state encoding for the modulator front end.
package mod_pkg;

  localparam int unsigned SIZE_INPUT_BIT = 8;
  localparam int unsigned SIZE_BIT_PACK  = 1976;
  localparam int unsigned SIZE_PREAMBLE  = 32;
  localparam logic [SIZE_PREAMBLE-1:0] PREAMBLE = 32'h1ACF_FC1D;

  // Preamble bytes, total bytes per pack, byte counter width
  localparam int unsigned NP       = SIZE_PREAMBLE / SIZE_INPUT_BIT;
  localparam int unsigned NT       = SIZE_BIT_PACK / SIZE_INPUT_BIT;
  localparam int unsigned SIZE_CNT = $clog2(NT);

  // ST_ prefix keeps the state literal apart from the PREAMBLE pattern constant
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_PAYLOAD,
    ST_BLANK
  } sched_state_t;

endpackage

// File: rtl/mod_pack_scheduler_preamble_rom.sv
// Maps the pack byte index to the preamble byte, MSB-first; zero past the preamble.
module mod_preamble_rom
  import mod_pkg::*;
(
  input  logic [SIZE_CNT-1:0]       idx,
  output logic [SIZE_INPUT_BIT-1:0] pre_byte_c
);

  // Unrolled compare against each preamble byte position
  always_comb begin
    pre_byte_c = '0;
    for (int k = 0; k < int'(NP); k++) begin
      if (idx == SIZE_CNT'(k)) begin
        pre_byte_c = PREAMBLE[SIZE_PREAMBLE-1-SIZE_INPUT_BIT*k -: SIZE_INPUT_BIT];
      end
    end
  end

endmodule

// File: rtl/mod_pack_scheduler.sv
// Frames the modulator byte stream into preamble + payload packs, filling gaps with blank packs.
module mod_pack_scheduler
  import mod_pkg::*;
#(
  parameter bit BLANK_FILL = 1'b1
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_enable,
  input  logic                      i_pkt_avail,
  input  logic [SIZE_INPUT_BIT-1:0] i_s_data,
  input  logic                      i_s_valid,
  output logic                      o_s_ready,
  output logic [SIZE_INPUT_BIT-1:0] o_data,
  output logic                      o_valid,
  input  logic                      i_mod_ready,
  output logic                      o_pack_type,
  output logic                      o_pack_done,
  output logic                      o_underrun,
  output logic [15:0]               o_pack_cnt
);

  sched_state_t              state_q, state_d;
  logic [SIZE_CNT-1:0]       cnt_q, cnt_d;
  logic                      pack_type_q, pack_type_d;
  logic                      pack_done_q, pack_done_d;
  logic                      underrun_q, underrun_d;
  logic [15:0]               pack_cnt_q, pack_cnt_d;
  logic [SIZE_INPUT_BIT-1:0] pre_byte_c;
  logic                      xfer_c;
  logic                      start_c;

  mod_preamble_rom u_rom (
    .idx        (cnt_q),
    .pre_byte_c (pre_byte_c)
  );

  assign o_pack_type = pack_type_q;
  assign o_pack_done = pack_done_q;
  assign o_underrun  = underrun_q;
  assign o_pack_cnt  = pack_cnt_q;

  // State and bookkeeping registers; reset aborts any pack in flight
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      pack_type_q <= 1'b0;
      pack_done_q <= 1'b0;
      underrun_q  <= 1'b0;
      pack_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pack_type_q <= pack_type_d;
      pack_done_q <= pack_done_d;
      underrun_q  <= underrun_d;
      pack_cnt_q  <= pack_cnt_d;
    end
  end

  // Byte-lane muxing plus next-state; payload is a zero-latency pass-through
  always_comb begin
    o_valid     = 1'b0;
    o_data      = '0;
    o_s_ready   = 1'b0;
    state_d     = state_q;
    cnt_d       = cnt_q;
    pack_type_d = pack_type_q;
    pack_done_d = 1'b0;
    underrun_d  = underrun_q;
    pack_cnt_d  = pack_cnt_q;

    start_c = i_enable && (i_pkt_avail || BLANK_FILL);

    case (state_q)
      ST_PREAMBLE: begin
        o_valid = 1'b1;
        o_data  = pre_byte_c;
      end
      ST_PAYLOAD: begin
        o_valid   = i_s_valid;
        o_data    = i_s_data;
        o_s_ready = i_mod_ready;
      end
      ST_BLANK: begin
        o_valid = 1'b1;
      end
      default: ;
    endcase

    xfer_c = o_valid && i_mod_ready;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (start_c) begin
          state_d     = ST_PREAMBLE;
          pack_type_d = i_pkt_avail;
        end
      end
      ST_PREAMBLE: begin
        if (xfer_c) begin
          cnt_d = cnt_q + SIZE_CNT'(1);
          if (cnt_q == SIZE_CNT'(NP - 1)) begin
            state_d = pack_type_q ? ST_PAYLOAD : ST_BLANK;
          end
        end
      end
      ST_PAYLOAD, ST_BLANK: begin
        if (state_q == ST_PAYLOAD && !i_s_valid) begin
          underrun_d = 1'b1;
        end
        if (xfer_c) begin
          if (cnt_q == SIZE_CNT'(NT - 1)) begin
            // Pack end: decide the next pack in this same cycle so packs run back to back
            cnt_d       = '0;
            pack_done_d = 1'b1;
            pack_cnt_d  = pack_cnt_q + 16'd1;
            if (start_c) begin
              state_d     = ST_PREAMBLE;
              pack_type_d = i_pkt_avail;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            cnt_d = cnt_q + SIZE_CNT'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mod_pack_scheduler.sv
// Directed bench for mod_pack_scheduler: blank/data packs, backpressure, underrun, disable, reset.
module tb_mod_pack_scheduler;

  logic       i_clk;
  logic       i_reset;
  logic       i_enable;
  logic       i_pkt_avail;
  logic [7:0] i_s_data;
  logic       i_s_valid;
  logic       o_s_ready;
  logic [7:0] o_data;
  logic       o_valid;
  logic       i_mod_ready;
  logic       o_pack_type;
  logic       o_pack_done;
  logic       o_underrun;
  logic [15:0] o_pack_cnt;

  mod_pack_scheduler dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_enable    (i_enable),
    .i_pkt_avail (i_pkt_avail),
    .i_s_data    (i_s_data),
    .i_s_valid   (i_s_valid),
    .o_s_ready   (o_s_ready),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .i_mod_ready (i_mod_ready),
    .o_pack_type (o_pack_type),
    .o_pack_done (o_pack_done),
    .o_underrun  (o_underrun),
    .o_pack_cnt  (o_pack_cnt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_tests;
  int n_fail;

  logic [7:0] pre_exp [4];
  logic [7:0] rxq [$];
  int         pidx;
  int         done_cnt;
  int         sready_cnt;
  int         stall_err;
  int         inval_cnt;
  logic       prev_stall;
  logic       prev_valid;
  logic [7:0] prev_data;

  // Expected byte k of a data pack whose payload is 00,01,02,...
  function automatic logic [7:0] exp_data(input int k);
    if (k < 4) return pre_exp[k];
    return 8'(k - 4);
  endfunction

  task automatic clear_rec();
    rxq.delete();
    pidx       = 0;
    done_cnt   = 0;
    sready_cnt = 0;
    stall_err  = 0;
    inval_cnt  = 0;
    prev_stall = 1'b0;
    prev_valid = 1'b0;
    prev_data  = 8'h00;
  endtask

  // One clock: drive at negedge, sample 1 ns later, record transfers and stall stability
  task automatic cycle(input logic mr, input logic sv);
    @(negedge i_clk);
    i_mod_ready = mr;
    i_s_valid   = sv;
    i_s_data    = 8'(pidx);
    #1;
    if (prev_stall && (o_valid !== prev_valid || o_data !== prev_data)) stall_err++;
    prev_stall = o_valid && !mr;
    prev_valid = o_valid;
    prev_data  = o_data;
    if (o_valid && mr) rxq.push_back(o_data);
    if (o_s_ready && sv) pidx++;
    if (o_s_ready) sready_cnt++;
    if (o_pack_done) done_cnt++;
    if (!o_valid) inval_cnt++;
  endtask

  task automatic do_reset();
    i_reset     = 1'b1;
    i_enable    = 1'b0;
    i_pkt_avail = 1'b0;
    i_mod_ready = 1'b0;
    i_s_valid   = 1'b0;
    i_s_data    = 8'h00;
    repeat (2) @(negedge i_clk);
    i_reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if (o_valid !== 1'b0 || o_s_ready !== 1'b0 || o_data !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_lane: valid=%b s_ready=%b data=%h want 0 0 00", o_valid, o_s_ready, o_data);
    end
    n_tests++;
    if (o_pack_done !== 1'b0 || o_underrun !== 1'b0 || o_pack_cnt !== 16'd0 || o_pack_type !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_status: done=%b underrun=%b cnt=%0d type=%b want 0 0 0 0",
               o_pack_done, o_underrun, o_pack_cnt, o_pack_type);
    end
    clear_rec();
    repeat (5) cycle(1'b1, 1'b1);
    n_tests++;
    if (inval_cnt !== 5) begin
      n_fail++;
      $display("FAIL idle_disabled: invalid cycles=%0d want 5", inval_cnt);
    end
  endtask

  task automatic test_blank();
    int guard;
    int mism;
    logic type_seen;
    logic [7:0] e;
    do_reset();
    clear_rec();
    i_enable = 1'b1;
    guard = 0;
    type_seen = 1'bx;
    while (rxq.size() < 247 && guard < 400) begin
      cycle(1'b1, 1'b0);
      if (guard == 0) type_seen = o_pack_type;
      guard++;
    end
    n_tests++;
    if (rxq.size() !== 247) begin
      n_fail++;
      $display("FAIL blank_len: bytes=%0d want 247", rxq.size());
    end
    mism = 0;
    foreach (rxq[k]) begin
      e = (k < 4) ? pre_exp[k] : 8'h00;
      if (rxq[k] !== e) mism++;
    end
    n_tests++;
    if (mism !== 0) begin
      n_fail++;
      $display("FAIL blank_bytes: mismatching bytes=%0d want 0", mism);
    end
    n_tests++;
    if (type_seen !== 1'b0) begin
      n_fail++;
      $display("FAIL blank_type: type=%b want 0", type_seen);
    end
    cycle(1'b1, 1'b0);
    n_tests++;
    if (o_pack_done !== 1'b1 || o_pack_cnt !== 16'd1 || done_cnt !== 1) begin
      n_fail++;
      $display("FAIL blank_done: done=%b cnt=%0d pulses=%0d want 1 1 1", o_pack_done, o_pack_cnt, done_cnt);
    end
    n_tests++;
    if (rxq.size() !== 248 || o_data !== 8'h1A || o_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL blank_no_gap: bytes=%0d valid=%b data=%h want 248 1 1a", rxq.size(), o_valid, o_data);
    end
    n_tests++;
    if (sready_cnt !== 0) begin
      n_fail++;
      $display("FAIL blank_sready: s_ready cycles=%0d want 0", sready_cnt);
    end
  endtask

  task automatic test_data();
    int guard;
    int mism;
    logic type_seen;
    do_reset();
    clear_rec();
    i_pkt_avail = 1'b1;
    i_enable    = 1'b1;
    guard = 0;
    type_seen = 1'bx;
    while (rxq.size() < 247 && guard < 400) begin
      cycle(1'b1, 1'b1);
      if (guard == 0) type_seen = o_pack_type;
      guard++;
    end
    mism = 0;
    foreach (rxq[k]) if (rxq[k] !== exp_data(k)) mism++;
    n_tests++;
    if (rxq.size() !== 247 || mism !== 0) begin
      n_fail++;
      $display("FAIL data_bytes: bytes=%0d mismatches=%0d want 247 0", rxq.size(), mism);
    end
    n_tests++;
    if (sready_cnt !== 243 || pidx !== 243) begin
      n_fail++;
      $display("FAIL data_sready: s_ready cycles=%0d accepted=%0d want 243 243", sready_cnt, pidx);
    end
    n_tests++;
    if (type_seen !== 1'b1 || o_underrun !== 1'b0) begin
      n_fail++;
      $display("FAIL data_flags: type=%b underrun=%b want 1 0", type_seen, o_underrun);
    end
  endtask

  task automatic test_backpressure();
    int c;
    int mism;
    logic mr;
    do_reset();
    clear_rec();
    i_pkt_avail = 1'b1;
    i_enable    = 1'b1;
    c = 0;
    while (rxq.size() < 247 && c < 1500) begin
      mr = (c % 4 == 0) || (c % 4 == 3);
      cycle(mr, 1'b1);
      c++;
    end
    mism = 0;
    foreach (rxq[k]) if (rxq[k] !== exp_data(k)) mism++;
    n_tests++;
    if (rxq.size() !== 247 || mism !== 0) begin
      n_fail++;
      $display("FAIL bp_bytes: bytes=%0d mismatches=%0d want 247 0", rxq.size(), mism);
    end
    n_tests++;
    if (stall_err !== 0 || pidx !== 243) begin
      n_fail++;
      $display("FAIL bp_stall: unstable stalls=%0d accepted=%0d want 0 243", stall_err, pidx);
    end
  endtask

  task automatic test_underrun();
    int guard;
    int mism;
    int gap;
    logic sv;
    logic u_before;
    do_reset();
    clear_rec();
    i_pkt_avail = 1'b1;
    i_enable    = 1'b1;
    guard = 0;
    gap = 3;
    u_before = 1'b0;
    while (rxq.size() < 247 && guard < 400) begin
      sv = 1'b1;
      if (pidx == 50 && gap > 0) begin
        sv = 1'b0;
        gap--;
      end
      cycle(1'b1, sv);
      if (pidx < 50) u_before = u_before | o_underrun;
      guard++;
    end
    mism = 0;
    foreach (rxq[k]) if (rxq[k] !== exp_data(k)) mism++;
    n_tests++;
    if (rxq.size() !== 247 || mism !== 0 || rxq[54] !== 8'h32) begin
      n_fail++;
      $display("FAIL ur_bytes: bytes=%0d mismatches=%0d want 247 0", rxq.size(), mism);
    end
    n_tests++;
    if (inval_cnt !== 3) begin
      n_fail++;
      $display("FAIL ur_gap: invalid cycles=%0d want 3", inval_cnt);
    end
    n_tests++;
    if (u_before !== 1'b0 || o_underrun !== 1'b1) begin
      n_fail++;
      $display("FAIL ur_flag: before=%b after=%b want 0 1", u_before, o_underrun);
    end
  endtask

  task automatic test_blank_to_data();
    int guard;
    do_reset();
    clear_rec();
    i_enable = 1'b1;
    guard = 0;
    while (rxq.size() < 252 && guard < 600) begin
      if (rxq.size() == 150) i_pkt_avail = 1'b1;
      cycle(1'b1, 1'b1);
      if (rxq.size() == 248 && o_pack_done) begin
        n_tests++;
        if (o_pack_type !== 1'b1) begin
          n_fail++;
          $display("FAIL b2d_type: type=%b want 1", o_pack_type);
        end
      end
      guard++;
    end
    n_tests++;
    if (rxq.size() !== 252 || rxq[247] !== 8'h1A || rxq[250] !== 8'h1D || pidx !== 1 || inval_cnt !== 0) begin
      n_fail++;
      $display("FAIL b2d_follow: bytes=%0d accepted=%0d gaps=%0d want 252 1 0", rxq.size(), pidx, inval_cnt);
    end
  endtask

  task automatic test_disable();
    int guard;
    do_reset();
    clear_rec();
    i_pkt_avail = 1'b1;
    i_enable    = 1'b1;
    guard = 0;
    while (rxq.size() < 247 && guard < 400) begin
      if (rxq.size() == 100) i_enable = 1'b0;
      cycle(1'b1, 1'b1);
      guard++;
    end
    cycle(1'b1, 1'b1);
    n_tests++;
    if (o_pack_done !== 1'b1 || o_valid !== 1'b0 || o_pack_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL dis_end: done=%b valid=%b cnt=%0d want 1 0 1", o_pack_done, o_valid, o_pack_cnt);
    end
    cycle(1'b1, 1'b1);
    n_tests++;
    if (o_valid !== 1'b0 || o_pack_done !== 1'b0 || rxq.size() !== 247) begin
      n_fail++;
      $display("FAIL dis_idle: valid=%b done=%b bytes=%0d want 0 0 247", o_valid, o_pack_done, rxq.size());
    end
  endtask

  task automatic test_reset_mid();
    int guard;
    do_reset();
    clear_rec();
    i_pkt_avail = 1'b1;
    i_enable    = 1'b1;
    guard = 0;
    while (rxq.size() < 120 && guard < 400) begin
      cycle(1'b1, 1'b1);
      guard++;
    end
    #2;
    i_reset = 1'b1;
    #1;
    n_tests++;
    if (o_valid !== 1'b0 || o_s_ready !== 1'b0 || o_data !== 8'h00 || o_pack_type !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid: valid=%b s_ready=%b data=%h type=%b want 0 0 00 0",
               o_valid, o_s_ready, o_data, o_pack_type);
    end
    @(negedge i_clk);
    i_reset = 1'b0;
    clear_rec();
    cycle(1'b1, 1'b1);
    n_tests++;
    if (rxq.size() !== 1 || o_data !== 8'h1A) begin
      n_fail++;
      $display("FAIL rst_restart: bytes=%0d data=%h want 1 1a", rxq.size(), o_data);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    pre_exp[0] = 8'h1A;
    pre_exp[1] = 8'hCF;
    pre_exp[2] = 8'hFC;
    pre_exp[3] = 8'h1D;
    test_reset();
    test_blank();
    test_data();
    test_backpressure();
    test_underrun();
    test_blank_to_data();
    test_disable();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
